sva_sample_tracker: RTL and testbench

SVA_SAMPLE_TRACKER -- requirements
Module: sva_sample_tracker

---
 rtl/sva_sample_tracker.sv | 136 +++++++++++++
 tb/tb_sva_sample_tracker.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sva_sample_tracker.sv
// Hardware equivalent of the SVA sampled-value functions ($stable, $changed, $rose, $fell, $past).
// Optional 16-bit change counter is built when SVA_SAMPLE_CHGCNT_EN is defined.
module sva_sample_tracker #(
  parameter int unsigned       WIDTH    = 8,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [WIDTH-1:0]  INIT_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       clr,
  input  logic [WIDTH-1:0]           data,
  input  logic [$clog2(DEPTH+1)-1:0] past_sel,
  output logic                       stable_o,
  output logic                       changed_o,
  output logic [WIDTH-1:0]           rose_o,
  output logic [WIDTH-1:0]           fell_o,
  output logic [WIDTH-1:0]           past_o,
`ifdef SVA_SAMPLE_CHGCNT_EN
  output logic [15:0]                change_cnt,
`endif
  output logic                       past_valid_o
);

  localparam int unsigned SW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_hist [DEPTH];
  logic [SW-1:0]    r_fill;
  logic             r_stable;
  logic             r_changed;
  logic [WIDTH-1:0] r_rose;
  logic [WIDTH-1:0] r_fell;
  logic [WIDTH-1:0] r_past;
  logic             r_past_valid;

  logic             w_accept;
  logic [SW-1:0]    w_n;
  logic [WIDTH-1:0] w_past;
  logic             w_past_valid;
  logic             w_same;

  assign w_accept = en & ~clr;
  assign w_same   = (data == r_hist[0]);

  // Requested depth: zero means one sample back, anything beyond DEPTH is clamped.
  always_comb begin
    w_n = past_sel;
    if (past_sel == '0) begin
      w_n = SW'(1);
    end else if (past_sel > SW'(DEPTH)) begin
      w_n = SW'(DEPTH);
    end
  end

  always_comb begin
    w_past = INIT_VAL;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (w_n == SW'(k + 1)) begin
        w_past = r_hist[k];
      end
    end
  end

  assign w_past_valid = (r_fill >= w_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_hist[k] <= INIT_VAL;
      end
      r_fill <= '0;
    end else if (clr) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_hist[k] <= INIT_VAL;
      end
      r_fill <= '0;
    end else if (en) begin
      r_hist[0] <= data;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        r_hist[k] <= r_hist[k-1];
      end
      if (r_fill != SW'(DEPTH)) begin
        r_fill <= r_fill + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable     <= 1'b0;
      r_changed    <= 1'b0;
      r_rose       <= '0;
      r_fell       <= '0;
      r_past       <= INIT_VAL;
      r_past_valid <= 1'b0;
    end else if (clr) begin
      r_stable     <= 1'b0;
      r_changed    <= 1'b0;
      r_rose       <= '0;
      r_fell       <= '0;
      r_past       <= INIT_VAL;
      r_past_valid <= 1'b0;
    end else if (w_accept) begin
      r_stable     <= w_same;
      r_changed    <= ~w_same;
      r_rose       <= data & ~r_hist[0];
      r_fell       <= ~data & r_hist[0];
      r_past       <= w_past;
      r_past_valid <= w_past_valid;
    end
  end

`ifdef SVA_SAMPLE_CHGCNT_EN
  logic [15:0] r_change_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_change_cnt <= '0;
    end else if (clr) begin
      r_change_cnt <= '0;
    end else if (w_accept && !w_same && (r_change_cnt != '1)) begin
      r_change_cnt <= r_change_cnt + 16'd1;
    end
  end

  assign change_cnt = r_change_cnt;
`endif

  assign stable_o     = r_stable;
  assign changed_o    = r_changed;
  assign rose_o       = r_rose;
  assign fell_o       = r_fell;
  assign past_o       = r_past;
  assign past_valid_o = r_past_valid;

endmodule

// File: tb/tb_sva_sample_tracker.sv
// Self-checking bench for sva_sample_tracker (WIDTH=8, DEPTH=4, INIT_VAL=0) against a queue-based model.
module tb_sva_sample_tracker;

  localparam int D  = 4;
  localparam int SW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          clr = 1'b0;
  logic [7:0]    data = 8'h00;
  logic [SW-1:0] past_sel = '0;
  logic          stable_o, changed_o, past_valid_o;
  logic [7:0]    rose_o, fell_o, past_o;
`ifdef SVA_SAMPLE_CHGCNT_EN
  logic [15:0]   change_cnt;
`endif

  sva_sample_tracker #(.WIDTH(8), .DEPTH(4), .INIT_VAL(8'h00)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .clr          (clr),
    .data         (data),
    .past_sel     (past_sel),
    .stable_o     (stable_o),
    .changed_o    (changed_o),
    .rose_o       (rose_o),
    .fell_o       (fell_o),
    .past_o       (past_o),
`ifdef SVA_SAMPLE_CHGCNT_EN
    .change_cnt   (change_cnt),
`endif
    .past_valid_o (past_valid_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: the real samples taken since reset/clr, newest first.
  logic [7:0] q[$];
  logic       m_stable, m_changed, m_pv;
  logic [7:0] m_rose, m_fell, m_past;
  int         m_cnt;

  function automatic int eff_n(input logic [SW-1:0] s);
    if (s == 0) return 1;
    if (int'(s) > D) return D;
    return int'(s);
  endfunction

  task automatic model_reset();
    q.delete();
    m_stable = 0; m_changed = 0; m_pv = 0;
    m_rose = 0; m_fell = 0; m_past = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    logic [7:0] prev;
    int n;
    if (!rst_n) return;
    if (clr) begin
      model_reset();
    end else if (en) begin
      prev      = (q.size() > 0) ? q[0] : 8'h00;
      n         = eff_n(past_sel);
      m_stable  = (data == prev);
      m_changed = (data != prev);
      m_rose    = data & ~prev;
      m_fell    = ~data & prev;
      m_pv      = (q.size() >= n);
      m_past    = (q.size() >= n) ? q[n-1] : 8'h00;
      if (data != prev && m_cnt < 65535) m_cnt++;
      q.push_front(data);
      if (q.size() > D) void'(q.pop_back());
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic e, input logic c, input logic [7:0] d, input logic [SW-1:0] s);
    en = e; clr = c; data = d; past_sel = s;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    check("stable",     64'(stable_o),     64'(m_stable));
    check("changed",    64'(changed_o),    64'(m_changed));
    check("rose",       64'(rose_o),       64'(m_rose));
    check("fell",       64'(fell_o),       64'(m_fell));
    check("past",       64'(past_o),       64'(m_past));
    check("past_valid", 64'(past_valid_o), 64'(m_pv));
`ifdef SVA_SAMPLE_CHGCNT_EN
    check("change_cnt", 64'(change_cnt),   64'(m_cnt));
`endif
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_stable", 64'(stable_o), 64'd0);
    check("rst_past",   64'(past_o),   64'h00);
    check("rst_pv",     64'(past_valid_o), 64'd0);
    rst_n = 1'b1;

    // Two samples of INIT_VAL
    step(1, 0, 8'h00, 0);
    check("first_stable", 64'(stable_o), 64'd1);
    check("first_pv",     64'(past_valid_o), 64'd0);
    step(1, 0, 8'h00, 0);
    check("s1_stable",  64'(stable_o),  64'd1);
    check("s1_changed", 64'(changed_o), 64'd0);
    check("s1_past",    64'(past_o),    64'h00);
    check("s1_pv",      64'(past_valid_o), 64'd1);

    step(1, 0, 8'h42, 0);
    check("s2_changed", 64'(changed_o), 64'd1);
    check("s2_stable",  64'(stable_o),  64'd0);
    step(1, 0, 8'h42, 0);
    check("s2_hold",    64'(stable_o),  64'd1);

    step(1, 0, 8'h01, 0);
    step(1, 0, 8'h00, 0);
    check("s3_fell",    64'(fell_o), 64'h01);
    step(1, 0, 8'h81, 0);
    check("s3_rose",    64'(rose_o), 64'h81);
    check("s3_fell0",   64'(fell_o), 64'h00);

    // clr discards data and resets outputs
    step(1, 1, 8'h55, 3);
    check("clr_past",   64'(past_o),       64'h00);
    check("clr_pv",     64'(past_valid_o), 64'd0);
    check("clr_rose",   64'(rose_o),       64'h00);
    step(1, 0, 8'h42, 3);
    step(1, 0, 8'h55, 3);
    step(1, 0, 8'hAA, 3);
    step(1, 0, 8'h11, 3);
    check("s4_past",    64'(past_o),       64'h42);
    check("s4_pv",      64'(past_valid_o), 64'd1);

    // Clamp: past_sel=7 behaves as N=4
    step(1, 1, 8'h00, 7);
    step(1, 0, 8'h01, 7);
    step(1, 0, 8'h02, 7);
    step(1, 0, 8'h03, 7);
    step(1, 0, 8'h04, 7);
    check("clamp_pv0",  64'(past_valid_o), 64'd0);
    step(1, 0, 8'h05, 7);
    check("clamp_pv1",  64'(past_valid_o), 64'd1);
    check("clamp_past", 64'(past_o),       64'h01);

    // Frozen while en=0, even with data and past_sel moving
    step(0, 0, 8'hFF, 1);
    step(0, 0, 8'h00, 2);
    step(0, 0, 8'h5A, 0);
    check("hold_past",   64'(past_o),       64'h01);
    check("hold_pv",     64'(past_valid_o), 64'd1);
    check("hold_stable", 64'(stable_o),     64'd0);
    step(1, 0, 8'h05, 7);
    check("thaw_stable", 64'(stable_o), 64'd1);
    check("thaw_past",   64'(past_o),   64'h02);

    step(1, 1, 8'h55, 7);
    check("clr2_stable", 64'(stable_o), 64'd0);
    step(1, 0, 8'h00, 7);
    check("clr2_first",  64'(stable_o), 64'd1);
    check("clr2_pv",     64'(past_valid_o), 64'd0);

    // Asynchronous reset between edges
    step(1, 0, 8'h3C, 1);
    step(1, 0, 8'hC3, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_rose",   64'(rose_o),   64'h00);
    check("arst_fell",   64'(fell_o),   64'h00);
    check("arst_change", 64'(changed_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random tail checked by the model
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
           8'($urandom_range(0, 3) == 0 ? 0 : $urandom), SW'($urandom_range(0, 7)));
    end

`ifdef SVA_SAMPLE_CHGCNT_EN
    step(1, 1, 8'h00, 1);
    step(1, 0, 8'h00, 1);
    step(1, 0, 8'h11, 1);
    step(1, 0, 8'h22, 1);
    step(1, 0, 8'h33, 1);
    check("cnt3", 64'(change_cnt), 64'd3);
    for (int i = 0; i < 65540; i++) begin
      step(1, 0, 8'(i), 1);
    end
    check("cnt_sat", 64'(change_cnt), 64'hFFFF);
`endif

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
